// File: rtl/grf_pkg.sv
// Shared constants for the multi-port general register file and its pending-write scoreboard.
package grf_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Writeback trace: time, writer PC, destination register, value.
  localparam string TRACE_FMT = "%d@%h: $%d <= %h";

  // Bits needed to count 0..nw same-cycle writebacks to one register.
  function automatic int dec_width(int nw);
    return (nw < 1) ? 1 : $clog2(nw + 1);
  endfunction

endpackage

// File: rtl/grf_pending_ctr.sv
// Per-register in-flight write counter: +1 on accepted issue, -dec on writebacks, clamped at 0.
module grf_pending_ctr #(
  parameter int CNT_W = 2,
  parameter int DECW  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic [DECW-1:0]  dec_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_max_o,
  output logic             uflow_o
);

  localparam int SW = (CNT_W + 1 > DECW) ? CNT_W + 1 : DECW;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sum;

  // Issue is added before the writebacks are removed, so a same-cycle pair nets to zero.
  always_comb begin
    sum     = SW'(cnt_q) + SW'(inc_i);
    uflow_o = (sum < SW'(dec_i));
    cnt_d   = cnt_q;
    if (flush_i || uflow_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = CNT_W'(sum - SW'(dec_i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = &cnt_q;

endmodule

// File: rtl/grf_scoreboard_mp.sv
// Multi-port register file with write-through bypass and per-register pending-write scoreboard.
module grf_scoreboard_mp
  import grf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int CNT_W    = 2,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NR*AW-1:0]     rd_addr,
  output logic [NR*DATA_W-1:0] rd_data,
  output logic [NR-1:0]        rd_busy,
  input  logic [NW-1:0]        wr_en,
  input  logic [NW*AW-1:0]     wr_addr,
  input  logic [NW*DATA_W-1:0] wr_data,
  input  logic [NW*32-1:0]     wr_pc,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_dst,
  output logic                 iss_ready,
  input  logic                 flush,
  output logic                 err_uflow
);

  localparam int DECW = dec_width(NW);

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt   [NUM_REGS];
  logic [DECW-1:0]     dec   [NUM_REGS];
  logic [NUM_REGS-1:0] inc, at_max, uflow;
  logic                err_uflow_q;
  logic                iss_ok;
  logic [AW-1:0]       ra;

  // r0 never counts writebacks, so its counter stays at zero.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) dec[r] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) dec[r] = dec[r] + DECW'(1);
      end
    end
  end

  assign iss_ready = (iss_dst == AW'(REG_ZERO)) || !at_max[iss_dst];
  assign iss_ok    = iss_valid && iss_ready && !flush && (iss_dst != AW'(REG_ZERO));

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) inc[r] = iss_ok && (iss_dst == AW'(r));
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_ctr
    grf_pending_ctr #(.CNT_W(CNT_W), .DECW(DECW)) u_ctr (
      .clk_i   (CLK),
      .rst_ni  (RESET_N),
      .inc_i   (inc[r]),
      .dec_i   (dec[r]),
      .flush_i (flush),
      .cnt_o   (cnt[r]),
      .at_max_o(at_max[r]),
      .uflow_o (uflow[r])
    );
  end

  // Highest-index writer wins the bypass; busy only if pending writes outnumber arrivals.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int i = 0; i < NR; i++) begin
      ra = rd_addr[i*AW +: AW];
      rd_data[i*DATA_W +: DATA_W] = mem_q[ra];
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j] && (ra != '0) && (wr_addr[j*AW +: AW] == ra))
          rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
      end
      rd_busy[i] = (ra != '0) && (32'(cnt[ra]) > 32'(dec[ra]));
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
      err_uflow_q <= 1'b0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != '0))
          mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
      end
      err_uflow_q <= err_uflow_q | (|uflow);
    end
  end

  assign err_uflow = err_uflow_q;

`ifndef SYNTHESIS
  function automatic logic port_wins(int j);
    for (int k = j + 1; k < NW; k++) begin
      if (wr_en[k] && (wr_addr[k*AW +: AW] == wr_addr[j*AW +: AW])) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge CLK) begin
    if (RESET_N) begin
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != '0) && port_wins(j))
          $display("%d@%h: $%d <= %h", $time, wr_pc[j*32 +: 32],
                   wr_addr[j*AW +: AW], wr_data[j*DATA_W +: DATA_W]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_grf_scoreboard_mp.sv
// Bench for grf_scoreboard_mp: hand vectors, corner sequences and a random run against a reference model.
module tb_grf_scoreboard_mp;

  localparam int DW = 32;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int CNT_MAX = 3;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic [NW*32-1:0]  wr_pc;
  logic              iss_valid;
  logic [AW-1:0]     iss_dst;
  logic              iss_ready;
  logic              flush;
  logic              err_uflow;

  grf_scoreboard_mp #(.DATA_W(DW), .NUM_REGS(NREG), .NR(NR), .NW(NW), .CNT_W(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(iss_ready),
    .flush(flush), .err_uflow(err_uflow)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [NREG];
  int            m_cnt [NREG];
  bit            m_err;

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_mem[r] = '0;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic int n_wr(int a);
    int n = 0;
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) n++;
    return n;
  endfunction

  function automatic logic [DW-1:0] exp_rd(int i);
    int a = int'(rd_addr[i*AW +: AW]);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_mem[a];
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*DW +: DW];
    return v;
  endfunction

  function automatic bit exp_busy(int i);
    int a = int'(rd_addr[i*AW +: AW]);
    if (a == 0) return 1'b0;
    return (m_cnt[a] - n_wr(a)) > 0;
  endfunction

  function automatic bit exp_ready();
    return (iss_dst == 0) || (m_cnt[iss_dst] < CNT_MAX);
  endfunction

  // Applies the inputs present at a rising edge to the model state.
  task automatic model_edge();
    bit acc = iss_valid && exp_ready() && !flush && (iss_dst != 0);
    int nc [NREG];
    for (int r = 1; r < NREG; r++) begin
      nc[r] = m_cnt[r] + ((acc && int'(iss_dst) == r) ? 1 : 0) - n_wr(r);
      if (nc[r] < 0) begin
        m_err = 1'b1;
        nc[r] = 0;
      end
      if (flush) nc[r] = 0;
    end
    for (int r = 1; r < NREG; r++) m_cnt[r] = nc[r];
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] != 0) m_mem[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("rd_data%0d", i), 64'(rd_data[i*DW +: DW]), 64'(exp_rd(i)));
      chk($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(exp_busy(i)));
    end
    chk("iss_ready", 64'(iss_ready), 64'(exp_ready()));
    chk("err_uflow", 64'(err_uflow), 64'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_pc = '0;
    iss_valid = 1'b0; iss_dst = '0; flush = 1'b0;
  endtask

  task automatic set_wr(int j, int a, logic [DW-1:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = AW'(a);
    wr_data[j*DW +: DW] = d;
    wr_pc[j*32 +: 32] = $urandom;
  endtask

  task automatic set_rd(int i, int a);
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic issue(int a);
    iss_valid = 1'b1;
    iss_dst = AW'(a);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    #3;
    compare_model();
    tick();
  endtask

  task automatic reset_pulse();
    idle();
    #3;
    RESET_N = 1'b0;
    #1;
    model_reset();
    chk("rst_rd0", 64'(rd_data[DW-1:0]), 64'(0));
    chk("rst_ready", 64'(iss_ready), 64'(1));
    chk("rst_err", 64'(err_uflow), 64'(0));
    #1;
    RESET_N = 1'b1;
    tick();
  endtask

  typedef struct {
    bit            we;
    int            wa;
    logic [DW-1:0] wd;
    int            ra;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1,  8, 32'h0000_DEAD,  8, 32'h0000_DEAD};
    tbl[1] = '{1'b0,  0, 32'h0,          8, 32'h0000_DEAD};
    tbl[2] = '{1'b1,  0, 32'hFFFF_FFFF,  0, 32'h0};
    tbl[3] = '{1'b0,  0, 32'h0,          0, 32'h0};
    tbl[4] = '{1'b1, 12, 32'h1111_1111,  8, 32'h0000_DEAD};
    tbl[5] = '{1'b0,  0, 32'h0,         12, 32'h1111_1111};
    tbl[6] = '{1'b1, 12, 32'h2222_2222, 12, 32'h2222_2222};
    tbl[7] = '{1'b0,  0, 32'h0,         12, 32'h2222_2222};
    tbl[8] = '{1'b1, 31, 32'hA5A5_A5A5, 31, 32'hA5A5_A5A5};
    tbl[9] = '{1'b0,  0, 32'h0,          5, 32'h0};

    idle();
    rd_addr = '0;
    model_reset();
    RESET_N = 1'b0;
    set_rd(0, 5);
    set_rd(1, 0);
    #7;
    chk("init_rd0", 64'(rd_data[DW-1:0]), 64'(0));
    chk("init_busy", 64'(rd_busy), 64'(0));
    chk("init_ready", 64'(iss_ready), 64'(1));
    chk("init_err", 64'(err_uflow), 64'(0));
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;

    // Table vectors: port-0 write and port-0 read each cycle
    for (int k = 0; k < 10; k++) begin
      idle();
      if (tbl[k].we) set_wr(0, tbl[k].wa, tbl[k].wd);
      set_rd(0, tbl[k].ra);
      #3;
      chk($sformatf("tbl%0d", k), 64'(rd_data[DW-1:0]), 64'(tbl[k].exp));
      compare_model();
      tick();
    end

    // Reset mid-run clears storage and the sticky error
    idle(); set_wr(0, 5, 32'h1234); set_rd(0, 5); cycle();
    idle(); #3;
    chk("r5_before_rst", 64'(rd_data[DW-1:0]), 64'(32'h1234));
    tick();
    reset_pulse();
    idle(); set_rd(0, 5); cycle();

    // Two pending writes to r3, retired by two same-cycle writebacks
    idle(); issue(3); cycle();
    idle(); issue(3); cycle();
    idle(); set_rd(1, 3); #3;
    chk("sb_busy_cnt2", 64'(rd_busy[1]), 64'(1));
    set_wr(0, 3, 32'hAAAA_0001); #1;
    chk("sb_busy_one_wb", 64'(rd_busy[1]), 64'(1));
    chk("sb_data_one_wb", 64'(rd_data[DW +: DW]), 64'(32'hAAAA_0001));
    set_wr(1, 3, 32'hBBBB_0002); #1;
    chk("sb_busy_two_wb", 64'(rd_busy[1]), 64'(0));
    chk("sb_data_two_wb", 64'(rd_data[DW +: DW]), 64'(32'hBBBB_0002));
    compare_model();
    tick();
    idle(); set_rd(1, 3); cycle();

    // Saturation on r9
    for (int k = 0; k < 3; k++) begin
      idle(); issue(9); cycle();
    end
    idle(); issue(9); #3;
    chk("sat_ready_r9", 64'(iss_ready), 64'(0));
    compare_model(); tick();
    idle(); issue(10); #3;
    chk("sat_ready_r10", 64'(iss_ready), 64'(1));
    compare_model(); tick();
    for (int k = 0; k < 3; k++) begin
      idle(); set_wr(0, 9, 32'h900 + k); set_rd(0, 9); cycle();
    end
    idle(); set_wr(1, 10, 32'hA00); set_rd(1, 9); cycle();
    idle(); #3;
    chk("sat_no_uflow", 64'(err_uflow), 64'(0));
    tick();

    // Two ports hit r4 in one cycle: port 1 wins, counter clamps
    idle(); issue(4); cycle();
    idle(); set_wr(0, 4, 32'h1); set_wr(1, 4, 32'h2); cycle();
    idle(); set_rd(0, 4); #3;
    chk("coll_data", 64'(rd_data[DW-1:0]), 64'(32'h2));
    chk("coll_uflow", 64'(err_uflow), 64'(1));
    compare_model(); tick();
    reset_pulse();

    // r0 ignores writes; flush clears pending counts and drops the issue
    idle(); set_wr(0, 0, 32'hFFFF_FFFF); set_rd(0, 0); cycle();
    idle(); set_rd(0, 0); cycle();
    idle(); issue(7); cycle();
    idle(); issue(7); cycle();
    idle(); flush = 1'b1; issue(11); set_rd(0, 7); #3;
    chk("flush_busy_before", 64'(rd_busy[0]), 64'(1));
    chk("flush_ready", 64'(iss_ready), 64'(1));
    compare_model(); tick();
    idle(); set_rd(0, 7); set_rd(1, 11); #3;
    chk("flush_busy_after", 64'(rd_busy[0]), 64'(0));
    chk("flush_issue_dropped", 64'(rd_busy[1]), 64'(0));
    compare_model(); tick();
    idle(); set_wr(0, 7, 32'h77); cycle();
    idle(); #3;
    chk("flush_late_wb_uflow", 64'(err_uflow), 64'(1));
    tick();
    reset_pulse();

    // Random traffic on a small register window
    for (int c = 0; c < 1500; c++) begin
      idle();
      for (int i = 0; i < NR; i++) set_rd(i, $urandom_range(0, 7));
      for (int j = 0; j < NW; j++) begin
        int a = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1 && (m_cnt[a] > 0 || a == 0 || $urandom_range(0, 19) == 0))
          set_wr(j, a, $urandom);
      end
      if ($urandom_range(0, 9) < 6) issue($urandom_range(0, 7));
      flush = ($urandom_range(0, 24) == 0);
      cycle();
      if (c % 300 == 299) reset_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
